// File: rtl/mdc_stein.sv
// mdc_stein: WIDTH-bit GCD engine, Stein binary algorithm, one op in flight.
// Ports: clk, rst_n, clear | in_valid/in_ready/in_a/in_b | out_valid/out_ready/out_gcd/out_zero/out_cycles
module mdc_stein #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_gcd,
   output logic             out_zero,
   output logic [CNT_W-1:0] out_cycles
);

   localparam int KW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE,
      COMMON,
      ITER,
      DONE
   } state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] a, b, a_nx, b_nx;
   logic [WIDTH-1:0] gcd_nx;
   logic [KW-1:0]    k, k_nx;
   logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
   logic [CNT_W-1:0] cyc_nx;
   logic             zero_nx;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         a          <= '0;
         b          <= '0;
         k          <= '0;
         cnt        <= '0;
         out_gcd    <= '0;
         out_zero   <= 1'b0;
         out_cycles <= '0;
      end else begin
         state      <= state_nx;
         a          <= a_nx;
         b          <= b_nx;
         k          <= k_nx;
         cnt        <= cnt_nx;
         out_gcd    <= gcd_nx;
         out_zero   <= zero_nx;
         out_cycles <= cyc_nx;
      end
   end

   always_comb begin
      // saturating cycle count
      cnt_inc  = (&cnt) ? cnt : cnt + CNT_W'(1);
      state_nx = state;
      a_nx     = a;
      b_nx     = b;
      k_nx     = k;
      cnt_nx   = cnt;
      gcd_nx   = out_gcd;
      zero_nx  = out_zero;
      cyc_nx   = out_cycles;
      if (clear) begin
         state_nx = IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  a_nx   = in_a;
                  b_nx   = in_b;
                  k_nx   = '0;
                  cnt_nx = '0;
                  if (in_a == '0 || in_b == '0) begin
                     state_nx = DONE;
                     gcd_nx   = in_a | in_b;
                     zero_nx  = (in_a == '0) && (in_b == '0);
                     cyc_nx   = '0;
                  end else begin
                     state_nx = COMMON;
                  end
               end
            end
            COMMON: begin
               cnt_nx = cnt_inc;
               if (!a[0] && !b[0]) begin
                  a_nx = a >> 1;
                  b_nx = b >> 1;
                  k_nx = k + KW'(1);
               end else begin
                  state_nx = ITER;
               end
            end
            ITER: begin
               cnt_nx = cnt_inc;
               if (a == b) begin
                  state_nx = DONE;
                  gcd_nx   = a << k;
                  zero_nx  = 1'b0;
                  cyc_nx   = cnt_inc;
               end else if (!a[0]) begin
                  a_nx = a >> 1;
               end else if (!b[0]) begin
                  b_nx = b >> 1;
               end else if (a > b) begin
                  a_nx = (a - b) >> 1;
               end else begin
                  b_nx = (b - a) >> 1;
               end
            end
            DONE: begin
               if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

endmodule
